// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: datapath widths, the
// FSM state encoding, the default starvation limit, the memory-port
// payload struct and a burst-length clamp helper.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BSEL_W = 2;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned MAX_BEATS = 4;

  // Consecutive CPU wins tolerated while a burst is pending.
  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // One cycle of traffic on the data-memory port.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BSEL_W-1:0] bsel;
  } mem_req_t;

  // Map a requested length onto 1..MAX_BEATS (0 means one beat).
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    res = len;
    if (len == '0) begin
      res = LEN_W'(1);
    end else if (len > LEN_W'(MAX_BEATS)) begin
      res = LEN_W'(MAX_BEATS);
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the data-memory port between the pipeline MEM stage and a
// burst engine. CPU accesses pass through combinationally with no added
// latency; a pending burst is granted when the CPU is quiet or after
// STARVE_LIMIT consecutive CPU wins, and then runs to completion one beat
// per cycle while the CPU is stalled.
//
// Ports:
//   Clock, Reset                  clock, synchronous active-high reset
//   CpuMemRead/Write, CpuAddress, CpuWriteData, CpuByteSel   CPU request
//   CpuReadData, CpuStall         CPU response / hold-request
//   BurstReq/Write/Address/Len/WriteData                     burst request
//   BurstAck/DataReq/ReadValid/Done, BurstReadData           burst response
//   MemAddress/WriteData/ByteSel/Read/Write, MemReadData     memory port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CpuMemRead,
  input  logic              CpuMemWrite,
  input  logic [ADDR_W-1:0] CpuAddress,
  input  logic [DATA_W-1:0] CpuWriteData,
  input  logic [BSEL_W-1:0] CpuByteSel,
  output logic [DATA_W-1:0] CpuReadData,
  output logic              CpuStall,
  input  logic              BurstReq,
  input  logic              BurstWrite,
  input  logic [ADDR_W-1:0] BurstAddress,
  input  logic [LEN_W-1:0]  BurstLen,
  input  logic [DATA_W-1:0] BurstWriteData,
  output logic              BurstAck,
  output logic              BurstDataReq,
  output logic              BurstReadValid,
  output logic              BurstDone,
  output logic [DATA_W-1:0] BurstReadData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic [BSEL_W-1:0] MemByteSel,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              burst_wr;

  logic              cpu_access_c;
  logic              starved_c;
  logic              grant_burst_c;
  logic              last_beat_c;
  logic [ADDR_W-1:0] beat_addr_c;
  mem_req_t          mem_req_c;

  // Burst start is word aligned; the byte-offset bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^BurstAddress[1:0];

  assign cpu_access_c  = CpuMemRead | CpuMemWrite;
  assign starved_c     = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign grant_burst_c = (state == ARB_IDLE) && BurstReq && (!cpu_access_c || starved_c);
  assign last_beat_c   = (state == ARB_BURST) && (LEN_W'(beat) == (burst_len - LEN_W'(1)));
  // Natural 32-bit wrap of the adder gives the required modulo addressing.
  assign beat_addr_c   = base_addr + ADDR_W'({beat, 2'b00});

  // Arbitration state, starvation counter and latched burst descriptor.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      beat       <= '0;
      base_addr  <= '0;
      burst_len  <= '0;
      burst_wr   <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_burst_c) begin
            state      <= ARB_BURST;
            starve_cnt <= '0;
            beat       <= '0;
            base_addr  <= {BurstAddress[ADDR_W-1:2], 2'b00};
            burst_len  <= clamp_len(BurstLen);
            burst_wr   <= BurstWrite;
          end else if (cpu_access_c && BurstReq && !starved_c) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
          end
        end
        ARB_BURST: begin
          if (last_beat_c) begin
            state <= ARB_IDLE;
            beat  <= '0;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory-port and handshake drive; everything is forced low during reset.
  always_comb begin
    mem_req_c      = '0;
    CpuReadData    = '0;
    CpuStall       = 1'b0;
    BurstAck       = 1'b0;
    BurstDataReq   = 1'b0;
    BurstReadValid = 1'b0;
    BurstDone      = 1'b0;
    BurstReadData  = '0;
    if (!Reset) begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_burst_c) begin
            // Grant cycle: port stays idle, CPU holds its request.
            BurstAck = 1'b1;
            CpuStall = cpu_access_c;
          end else if (cpu_access_c) begin
            // Read+write together is serviced as a write.
            mem_req_c.wr   = CpuMemWrite;
            mem_req_c.rd   = CpuMemRead & ~CpuMemWrite;
            mem_req_c.addr = CpuAddress;
            mem_req_c.bsel = CpuByteSel;
            if (CpuMemWrite) begin
              mem_req_c.wdata = CpuWriteData;
            end else begin
              CpuReadData = MemReadData;
            end
          end
        end
        ARB_BURST: begin
          CpuStall       = cpu_access_c;
          mem_req_c.addr = beat_addr_c;
          mem_req_c.bsel = '0;
          BurstDone      = last_beat_c;
          if (burst_wr) begin
            mem_req_c.wr    = 1'b1;
            mem_req_c.wdata = BurstWriteData;
            BurstDataReq    = 1'b1;
          end else begin
            mem_req_c.rd   = 1'b1;
            BurstReadValid = 1'b1;
            BurstReadData  = MemReadData;
          end
        end
        default: ;
      endcase
    end
  end

  assign MemRead      = mem_req_c.rd;
  assign MemWrite     = mem_req_c.wr;
  assign MemAddress   = mem_req_c.addr;
  assign MemWriteData = mem_req_c.wdata;
  assign MemByteSel   = mem_req_c.bsel;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 STARVE_LIMIT, 8, consecutive CPU wins with a burst pending before the burst is forced in.
REQ-002 Clock  in  1  single clock; all state on rising edge.
REQ-003 Reset  in  1  synchronous, active-high.
REQ-004 CpuMemRead / CpuMemWrite  in  1 each  pipeline MEM-stage access strobes.
REQ-005 CpuAddress / CpuWriteData  in  32 each  CPU address and store data.
REQ-006 CpuByteSel  in  2  CPU access size, passed through.
REQ-007 CpuReadData  out  32  MemReadData forwarded.
REQ-008 CpuStall  out  1  CPU access not serviced this cycle; hold request.
REQ-009 BurstReq / BurstWrite  in  1 each  burst request; 1 = write burst.
REQ-010 BurstAddress  in  32  burst start address, bits [1:0] ignored.
REQ-011 BurstLen  in  3  beats requested, 1..4.
REQ-012 BurstWriteData  in  32  current write-beat word.
REQ-013 BurstAck / BurstDataReq / BurstReadValid / BurstDone  out  1 each  request accepted / write word consumed / BurstReadData valid / last beat.
REQ-014 BurstReadData  out  32  read-beat word.
REQ-015 MemAddress / MemWriteData  out  32 each  data memory port.
REQ-016 MemByteSel  out  2;  MemRead / MemWrite  out  1 each  data memory controls.
REQ-017 MemReadData  in  32  data memory read, combinational from MemAddress.

Function
REQ-018 Two-state FSM: IDLE, BURST.
REQ-019 IDLE, CPU access, and (BurstReq=0 or StarveCnt<STARVE_LIMIT): CPU drives memory port combinationally, CpuStall=0, zero-cycle added latency.
REQ-020 IDLE, CPU wins with BurstReq=1: StarveCnt increments, saturating at STARVE_LIMIT.
REQ-021 IDLE, BurstReq=1, and (no CPU access or StarveCnt=STARVE_LIMIT): BurstAck pulses 1 cycle, address/len/write latched, StarveCnt cleared, next state BURST; memory idle this cycle; CpuStall=1 if CPU access present.
REQ-022 BurstLen latched: 0 -> 1, 5..7 -> 4.
REQ-023 BURST: one beat per cycle, MemAddress = {latched[31:2],2'b00} + 4*beat, 32-bit modulo wrap (0xFFFFFFFC -> 0x00000000); MemByteSel=2'b00.
REQ-024 Write beat: MemWrite=1, MemWriteData=BurstWriteData, BurstDataReq=1; engine presents next word the following cycle.
REQ-025 Read beat: MemRead=1, BurstReadValid=1, BurstReadData=MemReadData.
REQ-026 Last beat: BurstDone=1 same cycle, next state IDLE; bursts are never preempted.
REQ-027 BURST with CPU access: CpuStall=1 every cycle, no memory effect for the CPU.
REQ-028 BurstReq dropped before BurstAck = withdrawn request; no beats.
REQ-029 Back-to-back: in the IDLE cycle after BurstDone, a pending CPU access wins (StarveCnt=0).
REQ-030 CpuMemRead and CpuMemWrite both high: treated as write.
REQ-031 Idle port: MemRead=MemWrite=0, MemAddress/MemWriteData=0.

Reset
REQ-032 Reset forces IDLE, StarveCnt=0, beat counter 0, all outputs 0; mid-burst reset aborts without BurstDone.
REQ-033 First cycle after Reset deasserts arbitrates normally.

Structure
REQ-034 FSM state encoding and STARVE_LIMIT default belong in shared package dmem_pkg.
REQ-035 Single module, no sub-modules; instanced between MEM_STAGE control and the data memory.

Verification
REQ-036 CPU read 0x100 only, BurstReq=0 -> MemRead=1, MemAddress=0x100, CpuStall=0 same cycle.
REQ-037 Write burst 0x203, len 3, no CPU -> BurstAck, then 3 beats at 0x200/0x204/0x208, BurstDone on 3rd.
REQ-038 CPU access every cycle plus BurstReq -> CPU wins 8 cycles, then BurstAck; CPU stalls 1+len cycles.
REQ-039 Read burst 0xFFFFFFF8, len 4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; BurstLen 0 -> 1 beat; BurstLen 7 -> 4 beats.
REQ-040 Reset at beat 2 of 4 -> next cycle IDLE, all outputs 0, no BurstDone.
